// File: rtl/data_mem_copier_if.sv
// Data-memory bus between the copier (master) and a memory (slave).
// Ports: mem_address, mem_write_data, mem_read_write, mem_read_data.
interface data_mem_copier_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_read_write;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output mem_address,
    output mem_write_data,
    output mem_read_write,
    input  mem_read_data
  );

  modport slave (
    input  mem_address,
    input  mem_write_data,
    input  mem_read_write,
    output mem_read_data
  );
endinterface

// File: rtl/data_mem_copier.sv
// Forward byte copier: READ/WRITE loop over a combinational-read memory.
// Ports: clk, rst, start/src/dst/len request, busy/done status, mem bus.
module data_mem_copier #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  data_mem_copier_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_buf;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W-1:0] w_src_nx;
  logic [ADDR_W-1:0] w_dst_nx;
  logic              w_last;

  assign w_src_nx = r_src + ADDR_W'(1);
  assign w_dst_nx = r_dst + ADDR_W'(1);
  assign w_last   = (r_cnt == ADDR_W'(1));

  // Outputs are registered: the bus values for the next state are
  // loaded on the transition into it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_buf   <= '0;
      r_addr  <= '0;
      r_rw    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_src <= src;
            r_dst <= dst;
            r_cnt <= len;
            if (len != '0) begin
              r_state <= READ;
              r_addr  <= src;
              r_rw    <= 1'b0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        READ: begin
          r_buf   <= mem.mem_read_data;
          r_state <= WRITE;
          r_addr  <= r_dst;
          r_rw    <= 1'b1;
        end
        WRITE: begin
          r_src <= w_src_nx;
          r_dst <= w_dst_nx;
          r_cnt <= r_cnt - ADDR_W'(1);
          r_rw  <= 1'b0;
          if (w_last) begin
            // address keeps the last write target while idle
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state <= READ;
            r_addr  <= w_src_nx;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign mem.mem_address    = r_addr;
  assign mem.mem_write_data = r_buf;
  assign mem.mem_read_write = r_rw;

endmodule

// File: tb/tb_data_mem_copier.sv
// Directed bench for data_mem_copier with a write scoreboard.
// Expected writes come from a shadow memory copied forward byte by byte.
module tb_data_mem_copier;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src = '0;
  logic [7:0] dst = '0;
  logic [7:0] len = '0;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  wr_t        q [$];
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  data_mem_copier_if #(.ADDR_W(8), .DATA_W(8)) mif ();

  assign mif.mem_read_data = mem[mif.mem_address];

  always @(posedge clk)
    if (mif.mem_read_write)
      mem[mif.mem_address] <= mif.mem_write_data;

  data_mem_copier #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .src   (src),
    .dst   (dst),
    .len   (len),
    .busy  (busy),
    .done  (done),
    .mem   (mif)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every observed write must match the oldest expected one
  always @(negedge clk) begin
    if (mif.mem_read_write === 1'b1) begin
      wr_t e;
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_write: observed addr=%0h expected none",
               mif.mem_address);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", 32'(mif.mem_address), 32'(e.a));
        check("wr_data", 32'(mif.mem_write_data), 32'(e.d));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic expect_copy(input logic [7:0] s,
                             input logic [7:0] d,
                             input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] ra;
      logic [7:0] wa;
      logic [7:0] v;
      ra = s + 8'(i);
      wa = d + 8'(i);
      v = ref_mem[ra];
      ref_mem[wa] = v;
      q.push_back({wa, v});
    end
  endtask

  task automatic check_mem(input string tag,
                           input logic [7:0] a,
                           input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] x;
      x = a + 8'(i);
      check(tag, 32'(mem[x]), 32'(ref_mem[x]));
    end
  endtask

  task automatic run_copy(input string tag,
                          input logic [7:0] s,
                          input logic [7:0] d,
                          input int n);
    int k;
    int bc;
    int dk;
    expect_copy(s, d, n);
    src = s;
    dst = d;
    len = 8'(n);
    start = 1'b1;
    tick;
    start = 1'b0;
    k = 0;
    bc = 0;
    dk = -1;
    while (k < 600) begin
      if (done) begin
        dk = k;
        break;
      end
      if (busy) bc++;
      tick;
      k++;
    end
    check({tag, "_done_cycle"}, 32'(dk), 32'(2 * n));
    check({tag, "_busy_cycles"}, 32'(bc), 32'(2 * n));
    check({tag, "_busy_at_done"}, 32'(busy), 32'(0));
    tick;
    check({tag, "_done_pulse"}, 32'(done), 32'(0));
    check({tag, "_rw_idle"}, 32'(mif.mem_read_write), 32'(0));
    check({tag, "_sb_empty"}, 32'(q.size()), 32'(0));
  endtask

  initial begin
    int nd;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      ref_mem[i] = 8'(i) ^ 8'h5A;
    end

    // reset wins over a simultaneous start
    rst = 1'b1;
    start = 1'b1;
    src = 8'd3;
    dst = 8'd4;
    len = 8'd2;
    tick;
    tick;
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rw", 32'(mif.mem_read_write), 32'(0));
    check("rst_addr", 32'(mif.mem_address), 32'(0));
    check("rst_wdata", 32'(mif.mem_write_data), 32'(0));
    start = 1'b0;
    rst = 1'b0;
    tick;

    // basic copy
    poke(8'd100, 8'h11);
    poke(8'd101, 8'h22);
    poke(8'd102, 8'h33);
    run_copy("basic", 8'd100, 8'd200, 3);
    check("basic_m200", 32'(mem[200]), 32'h11);
    check("basic_m201", 32'(mem[201]), 32'h22);
    check("basic_m202", 32'(mem[202]), 32'h33);
    check("basic_addr_hold", 32'(mif.mem_address), 32'd202);
    check("basic_wdata_buf", 32'(mif.mem_write_data), 32'h33);

    // empty copy
    run_copy("empty", 8'd5, 8'd9, 0);
    check_mem("empty_m9", 8'd9, 1);

    // wrap around the top of the address space
    poke(8'd254, 8'hA1);
    poke(8'd255, 8'hB2);
    poke(8'd0, 8'hC3);
    poke(8'd1, 8'hD4);
    run_copy("wrap", 8'd254, 8'd10, 4);
    check("wrap_m10", 32'(mem[10]), 32'hA1);
    check("wrap_m11", 32'(mem[11]), 32'hB2);
    check("wrap_m12", 32'(mem[12]), 32'hC3);
    check("wrap_m13", 32'(mem[13]), 32'hD4);

    // a second start while busy is dropped
    expect_copy(8'd20, 8'd30, 3);
    src = 8'd20;
    dst = 8'd30;
    len = 8'd3;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    dst = 8'd50;
    start = 1'b1;
    tick;
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick;
    end
    check("busy_start_pulses", 32'(nd), 32'd1);
    check("busy_start_m50", 32'(mem[50]), 32'(8'd50 ^ 8'h5A));
    check_mem("busy_start_dst", 8'd30, 3);
    check("busy_start_sb", 32'(q.size()), 32'(0));

    // overlapping forward copy smears the first byte
    poke(8'd100, 8'h07);
    run_copy("overlap", 8'd100, 8'd101, 3);
    check("overlap_m101", 32'(mem[101]), 32'h07);
    check("overlap_m102", 32'(mem[102]), 32'h07);
    check("overlap_m103", 32'(mem[103]), 32'h07);

    // reset at the edge that ends the second write
    expect_copy(8'd60, 8'd70, 2);
    src = 8'd60;
    dst = 8'd70;
    len = 8'd5;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    check("midrst_in_write", 32'(mif.mem_read_write), 32'd1);
    rst = 1'b1;
    tick;
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_rw", 32'(mif.mem_read_write), 32'(0));
    check("midrst_addr", 32'(mif.mem_address), 32'(0));
    check("midrst_wdata", 32'(mif.mem_write_data), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick;
    check_mem("midrst_mem", 8'd70, 5);
    check("midrst_m72", 32'(mem[72]), 32'(8'd72 ^ 8'h5A));
    check("midrst_sb", 32'(q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
